host_read_port: RTL
===================

HOST_READ_PORT -- requirements
Module: host_read_port

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, 2..16.
REQ-002 clock  in  1  system clock; all state SHALL be updated on its rising edge.
REQ-003 nRESET  in  1  asynchronous, active-low reset.
REQ-004 tgt_data  in  8  byte from the target controller to be returned to the host.
REQ-005 tgt_wr  in  1  one-clock write strobe, synchronous to clock.
REQ-006 tgt_full  out  1  high when the FIFO holds DEPTH entries.
REQ-007 tgt_overflow  out  1  sticky flag, set on a write while full.
REQ-008 host_rd  in  1  host bus read strobe, asynchronous, active-high.
REQ-009 host_data  out  8  head-of-FIFO byte presented to the host data bus.
REQ-010 host_drdy  out  1  high when the FIFO is non-empty.
REQ-011 host_irq  out  1  host interrupt request (see Configuration).

Function
REQ-012 The block SHALL be a DEPTH-entry FIFO: the target side writes, the host side reads.
REQ-013 Write rules:
- tgt_wr while not full SHALL store tgt_data at the tail and increment the count in the same clock.
- tgt_wr while full SHALL be discarded and SHALL set tgt_overflow.
REQ-014 host_rd SHALL pass through a two-flop synchronizer before any use.
REQ-015 Read state machine:
- States: IDLE, ACTIVE, POP.
- IDLE->ACTIVE on the synchronized rising edge of host_rd.
- ACTIVE->POP on the synchronized falling edge.
- POP->IDLE after one clock.
REQ-016 In POP, the head entry SHALL be removed only if the FIFO is non-empty; a read of an empty FIFO SHALL leave the count unchanged.
REQ-017 host_data SHALL be a registered copy of the head entry.
- It SHALL hold constant throughout ACTIVE, even if a write occurs.
- It SHALL update in the clock after POP, or in the clock after a write into an empty FIFO while IDLE.
- When the FIFO is empty, it SHALL hold 8'h00.
REQ-018 Simultaneous write and POP in one clock SHALL perform both operations; the count SHALL stay unchanged, and a full FIFO SHALL accept that write.
REQ-019 Pointers SHALL wrap modulo DEPTH. The count width SHALL be log2(DEPTH)+1.
REQ-020 tgt_full and host_drdy SHALL be registered and reflect the count after the current clock's operations.
REQ-021 host_drdy SHALL deassert no later than 4 clocks after host_rd falls on the read that empties the FIFO.
REQ-022 A second host_rd rising edge seen during POP SHALL be held and handled from IDLE in the next clock.

Reset
REQ-023 On nRESET low, asynchronously:
- Count and pointers SHALL clear.
- The state machine SHALL enter IDLE.
- The synchronizer SHALL clear.
- host_data SHALL be 8'h00.
- host_drdy, host_irq, tgt_full and tgt_overflow SHALL be 0.
REQ-024 A reset asserted during ACTIVE SHALL abort the read without popping. After release, a host_rd that is still high SHALL NOT be treated as a new rising edge.
REQ-025 tgt_overflow SHALL clear only on reset.

Configuration
REQ-026 Macro HOST_READ_IRQ_EN.
- Defined: host_irq SHALL be registered and set when the FIFO goes from empty to non-empty. It SHALL clear on entry to ACTIVE and re-set after POP if the FIFO is still non-empty.
- Undefined: host_irq SHALL be tied to 0 and no IRQ logic shall be synthesized.

Verification
REQ-027 Reset, then write 8'hA5 -> host_drdy=1 and host_data=8'hA5 within 2 clocks; host read pulse -> host_drdy=0 within 4 clocks after host_rd falls.
REQ-028 Write 8'h01..8'h04 (DEPTH=4) -> tgt_full=1. Write 8'h05 -> tgt_overflow=1. Four host reads -> 8'h01,8'h02,8'h03,8'h04 in order; 8'h05 is never returned.
REQ-029 Full FIFO, tgt_wr of 8'h55 in the same clock as POP -> count stays 4, tgt_full stays 1; subsequent reads return the remaining three entries, then 8'h55.
REQ-030 Assert host_rd on an empty FIFO -> count stays 0, host_data=8'h00, and no underflow corruption on the next write of 8'h3C.
REQ-031 Assert nRESET during ACTIVE with 2 entries, release while host_rd is still high -> FIFO empty, no pop on host_rd falling; the next write of 8'h77 reads back 8'h77.
REQ-032 With HOST_READ_IRQ_EN defined: write -> host_irq=1; host_rd rises -> host_irq=0; after POP with one entry left -> host_irq=1. With the macro undefined: host_irq stays 0 throughout.

Source files
------------

// File: rtl/host_read_port_if.sv
// Target/host bus bundle for the host read port FIFO.
interface host_read_port_if;
  logic [7:0] tgt_data;
  logic       tgt_wr;
  logic       tgt_full;
  logic       tgt_overflow;
  logic       host_rd;
  logic [7:0] host_data;
  logic       host_drdy;
  logic       host_irq;

  modport master (
    output tgt_data, tgt_wr, host_rd,
    input  tgt_full, tgt_overflow,
    input  host_data, host_drdy, host_irq
  );

  modport slave (
    input  tgt_data, tgt_wr, host_rd,
    output tgt_full, tgt_overflow,
    output host_data, host_drdy, host_irq
  );
endinterface

// File: rtl/host_read_port.sv
// Target-to-host byte FIFO with a synchronized host read strobe.
// Optional host interrupt enabled by macro HOST_READ_IRQ_EN.
module host_read_port #(
  parameter int DEPTH = 4
) (
  input logic        clock,
  input logic        nRESET,
  host_read_port_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    POP
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_nx;
  logic [CW-1:0] count, count_nx;
  logic          rd_s1, rd_s2, rd_s3;
  logic          armed;
  logic [1:0]    settle;
  logic          rise, fall;
  logic          pend, pend_nx;
  state_t        state, state_nx;
  logic          push, pop, hd_load;
  logic [7:0]    head_nx;
  logic [7:0]    data_q;
  logic          full_q, drdy_q, ovf_q;

  // Edges are ignored until the synchronizer has seen host_rd low
  // after reset, so a strobe held across reset is not a new read.
  always_comb begin
    rise = rd_s2 & ~rd_s3 & armed;
    fall = ~rd_s2 & rd_s3 & armed;
  end

  always_comb begin
    pop      = (state == POP) && (count != '0);
    push     = bus.tgt_wr &&
               ((count != CW'(DEPTH)) || pop);
    count_nx = count + CW'(push) - CW'(pop);
    rptr_nx  = rptr + AW'(pop);
    hd_load  = (state == POP) ||
               ((state == IDLE) && (count == '0));
    head_nx  = 8'h00;
    if (count_nx == '0)
      head_nx = 8'h00;
    else if (push && ((count - CW'(pop)) == '0))
      head_nx = bus.tgt_data;
    else
      head_nx = mem[rptr_nx];
  end

  always_comb begin
    state_nx = state;
    pend_nx  = pend;
    unique case (1'b1)
      state == IDLE: begin
        if (rise || pend) begin
          state_nx = ACTIVE;
          pend_nx  = 1'b0;
        end
      end
      state == ACTIVE: begin
        if (fall)
          state_nx = POP;
      end
      state == POP: begin
        state_nx = IDLE;
        if (rise)
          pend_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wptr] <= bus.tgt_data;
  end

  always_ff @(posedge clock or negedge nRESET) begin
    if (!nRESET) begin
      rd_s1  <= 1'b0;
      rd_s2  <= 1'b0;
      rd_s3  <= 1'b0;
      settle <= '0;
      armed  <= 1'b0;
      state  <= IDLE;
      pend   <= 1'b0;
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      data_q <= 8'h00;
      full_q <= 1'b0;
      drdy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      rd_s1  <= bus.host_rd;
      rd_s2  <= rd_s1;
      rd_s3  <= rd_s2;
      settle <= {settle[0], 1'b1};
      armed  <= armed | (settle[1] & ~rd_s2);
      state  <= state_nx;
      pend   <= pend_nx;
      wptr   <= wptr + AW'(push);
      rptr   <= rptr_nx;
      count  <= count_nx;
      full_q <= (count_nx == CW'(DEPTH));
      drdy_q <= (count_nx != '0);
      if (bus.tgt_wr && !push)
        ovf_q <= 1'b1;
      if (hd_load)
        data_q <= head_nx;
    end
  end

`ifdef HOST_READ_IRQ_EN
  logic irq_q;

  always_ff @(posedge clock or negedge nRESET) begin
    if (!nRESET) begin
      irq_q <= 1'b0;
    end else if (state == IDLE && state_nx == ACTIVE) begin
      irq_q <= 1'b0;
    end else if (count == '0 && count_nx != '0) begin
      irq_q <= 1'b1;
    end else if (state == POP && count_nx != '0) begin
      irq_q <= 1'b1;
    end
  end

  assign bus.host_irq = irq_q;
`else
  assign bus.host_irq = 1'b0;
`endif

  assign bus.tgt_full     = full_q;
  assign bus.tgt_overflow = ovf_q;
  assign bus.host_data    = data_q;
  assign bus.host_drdy    = drdy_q;

endmodule
